// File: rtl/nios2_system_edge_capture_pio.sv
// Avalon-MM input PIO: per-bit synchroniser, edge capture with clear-on-write,
// interrupt mask and a level irq derived purely from registered state.
module nios2_system_edge_capture_pio #(
    parameter int WIDTH        = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int EDGE_TYPE    = 0,
    parameter int BIT_CLEARING = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int WARM_LEN = SYNC_STAGES + 1;
    localparam int CW       = $clog2(WARM_LEN + 1);
    localparam logic [CW-1:0] WARM_MAX = CW'(WARM_LEN);

    logic [WIDTH-1:0] sync_stage_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] edge_d;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clr_bits;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;
    logic [CW-1:0]    warm_cnt_q;
    logic             warm;
    logic             wr_en;
    logic             wr_mask;
    logic             wr_edge;
    logic             wdata_unused;

    // Synchroniser chain; stage 0 is the only flop that sees the raw input.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (reset) begin
                    sync_stage_q[gi] <= '0;
                end else if (gi == 0) begin
                    sync_stage_q[gi] <= in_port;
                end else begin
                    sync_stage_q[gi] <= sync_stage_q[(gi > 0) ? gi - 1 : 0];
                end
            end
        end
    endgenerate

    assign sync_q       = sync_stage_q[SYNC_STAGES-1];
    assign warm         = (warm_cnt_q == WARM_MAX);
    assign wr_en        = chipselect && !write_n;
    assign wr_mask      = wr_en && (address == 2'd2);
    assign wr_edge      = wr_en && (address == 2'd3);
    assign wdata_unused = ^writedata;

    always_comb begin
        edge_det = '0;
        if (warm) begin
            case (EDGE_TYPE)
                0:       edge_det = sync_q & ~prev_q;
                1:       edge_det = ~sync_q & prev_q;
                default: edge_det = sync_q ^ prev_q;
            endcase
        end
    end

    // A clear never beats a detected edge on the same bit.
    always_comb begin
        clr_bits = '0;
        if (wr_edge) begin
            clr_bits = (BIT_CLEARING != 0) ? writedata[WIDTH-1:0] : '1;
        end
        edge_d = (edge_q & ~clr_bits) | edge_det;
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            2'd0:    readdata_d[WIDTH-1:0] = sync_q;
            2'd2:    readdata_d[WIDTH-1:0] = mask_q;
            2'd3:    readdata_d[WIDTH-1:0] = edge_q;
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q     <= '0;
            mask_q     <= '0;
            edge_q     <= '0;
            readdata_q <= '0;
            warm_cnt_q <= '0;
        end else begin
            prev_q     <= sync_q;
            edge_q     <= edge_d;
            readdata_q <= readdata_d;
            if (wr_mask) begin
                mask_q <= writedata[WIDTH-1:0];
            end
            if (!warm) begin
                warm_cnt_q <= warm_cnt_q + 1'b1;
            end
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_q & mask_q);

endmodule

// File: tb/tb_nios2_system_edge_capture_pio.sv
// Three PIO configurations on a shared bus, checked against a sample-log model.
module tb_nios2_system_edge_capture_pio;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rd0, rd1, rd2;
    logic        irq0, irq1, irq2;

    always #5 clk = ~clk;

    nios2_system_edge_capture_pio #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .BIT_CLEARING(1)) u0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port), .readdata(rd0), .irq(irq0));
    nios2_system_edge_capture_pio #(.WIDTH(8), .SYNC_STAGES(3), .EDGE_TYPE(2), .BIT_CLEARING(1)) u1 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port), .readdata(rd1), .irq(irq1));
    nios2_system_edge_capture_pio #(.WIDTH(8), .SYNC_STAGES(4), .EDGE_TYPE(1), .BIT_CLEARING(0)) u2 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port), .readdata(rd2), .irq(irq2));

    int cfg_s [3] = '{2, 3, 4};
    int cfg_e [3] = '{0, 2, 1};
    int cfg_b [3] = '{1, 1, 0};

    typedef struct packed {
        int              due;
        logic [2:0][31:0] rd;
        logic [2:0]       irq;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] in_log [$];   // in_port sampled on each edge since reset release
    logic [7:0] m_mask [3];
    logic [7:0] m_ec [3];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronised value after n post-release edges: input seen S edges earlier.
    function automatic logic [7:0] syncv(int s, int n);
        return (n >= s) ? in_log[n-s] : 8'h00;
    endfunction

    task automatic cycle(input logic rst, input logic cs, input logic wn,
                         input logic [1:0] ad, input logic [31:0] wd, input logic [7:0] inp);
        exp_t       e;
        int         n;
        logic [7:0] sn, sp, ed, clr, nec;
        reset = rst; chipselect = cs; write_n = wn; address = ad; writedata = wd; in_port = inp;
        e.due = cyc + 1;
        n = in_log.size();
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_ec[k] = 8'h00; m_mask[k] = 8'h00;
                e.rd[k] = 32'h0; e.irq[k] = 1'b0;
            end else begin
                sn = syncv(cfg_s[k], n);
                sp = syncv(cfg_s[k], n - 1);
                case (cfg_e[k])
                    0:       ed = sn & ~sp;
                    1:       ed = ~sn & sp;
                    default: ed = sn ^ sp;
                endcase
                if (n < cfg_s[k] + 1) ed = 8'h00;
                case (ad)
                    2'd0:    e.rd[k] = {24'h0, sn};
                    2'd2:    e.rd[k] = {24'h0, m_mask[k]};
                    2'd3:    e.rd[k] = {24'h0, m_ec[k]};
                    default: e.rd[k] = 32'h0;
                endcase
                clr = 8'h00;
                if (cs && !wn && ad == 2'd3) clr = (cfg_b[k] != 0) ? wd[7:0] : 8'hFF;
                nec = (m_ec[k] & ~clr) | ed;
                m_ec[k] = nec;
                if (cs && !wn && ad == 2'd2) m_mask[k] = wd[7:0];
                e.irq[k] = |(m_ec[k] & m_mask[k]);
            end
        end
        if (rst) in_log.delete();
        else     in_log.push_back(inp);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] ad, input logic [7:0] inp);
        cycle(1'b0, 1'b1, 1'b1, ad, 32'h0, inp);
    endtask

    task automatic wr(input logic [1:0] ad, input logic [31:0] wd, input logic [7:0] inp);
        cycle(1'b0, 1'b1, 1'b0, ad, wd, inp);
    endtask

    // Monitor: readdata and irq are presented every cycle, one edge after issue.
    always @(negedge clk) begin
        logic [2:0][31:0] got_rd;
        logic [2:0]       got_irq;
        exp_t             e;
        got_rd  = {rd2, rd1, rd0};
        got_irq = {irq2, irq1, irq0};
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (e.due != cyc || got_rd[k] !== e.rd[k]) begin
                    errors++;
                    $display("FAIL readdata inst%0d cyc%0d due%0d got %h want %h", k, cyc, e.due, got_rd[k], e.rd[k]);
                end
                checks++;
                if (e.due != cyc || got_irq[k] !== e.irq[k]) begin
                    errors++;
                    $display("FAIL irq inst%0d cyc%0d due%0d got %b want %b", k, cyc, e.due, got_irq[k], e.irq[k]);
                end
            end
        end
    end

    initial begin
        logic [7:0] cur;
        // Inputs high through reset must not appear as edges after release.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 2'd0, 32'h0, 8'hFF);
        for (int i = 0; i < 12; i++) rd((i % 2 == 0) ? 2'd3 : 2'd0, 8'hFF);
        $display("phase reset-high done cyc %0d", cyc);

        wr(2'd2, 32'h1, 8'hFF);
        for (int i = 0; i < 6; i++) rd(2'd3, 8'hFE);
        wr(2'd3, 32'hFF, 8'hFE);
        for (int i = 0; i < 7; i++) rd(2'd3, 8'hFF);
        wr(2'd3, 32'h1, 8'hFF);
        rd(2'd3, 8'hFF);
        $display("phase rise/clear done cyc %0d", cyc);

        // Clear every cycle while bit0 toggles: hits same-cycle set and clear.
        cur = 8'hFF;
        for (int i = 0; i < 16; i++) begin
            if (i % 3 == 0) cur[0] = ~cur[0];
            wr(2'd3, 32'h1, cur);
        end
        for (int i = 0; i < 6; i++) rd(2'd3, cur);
        $display("phase set-wins done cyc %0d", cyc);

        wr(2'd2, 32'h0, cur);
        wr(2'd3, 32'hFF, cur);
        cur = cur ^ 8'h28;
        for (int i = 0; i < 7; i++) rd(2'd3, cur);
        wr(2'd2, 32'h20, cur);
        rd(2'd3, cur);
        wr(2'd3, 32'h08, cur);
        rd(2'd3, cur);
        rd(2'd2, cur);
        $display("phase any-edge/mask done cyc %0d", cyc);

        wr(2'd2, 32'hFF, cur);
        cur = 8'h55;
        for (int i = 0; i < 6; i++) rd(2'd3, cur);
        cur = 8'hAA;
        for (int i = 0; i < 6; i++) rd(2'd3, cur);
        wr(2'd3, 32'h0, cur);
        rd(2'd3, cur);
        cycle(1'b1, 1'b1, 1'b1, 2'd3, 32'h0, 8'h0F);
        for (int i = 0; i < 8; i++) rd(2'd3, 8'h0F);
        $display("phase mid-reset done cyc %0d", cyc);

        for (int i = 0; i < 2000; i++) begin
            logic [1:0]  ad;
            logic [31:0] wd;
            ad = 2'($urandom_range(0, 3));
            wd = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            if ($urandom_range(0, 2) == 0) cur = cur ^ 8'($urandom & $urandom);
            if ($urandom_range(0, 299) == 0)
                cycle(1'b1, 1'($urandom), 1'($urandom), ad, wd, cur);
            else
                cycle(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0), ad, wd, cur);
        end
        for (int i = 0; i < 4; i++) rd(2'd3, cur);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
